rgb_filter_ctrl: RTL and testbench

Sequences the per-channel attenuation code (filter_SW[5:0]: [5:4] R, [3:2] G, [1:0] B; 00 normal, 01 half, 10 quarter, 11 off) fed to the RGB filter datapath. Debounces board switches, and commits a new code only at a frame boundary so no frame is displayed with mixed settings. Adds an auto-cycle mode, toggled by a pushbutton, that steps through fixed presets every AUTO_FRAMES frames. Sits between the board switch/key inputs and the RGB filter stage, in the VGA pixel clock domain.

---
 rtl/rgb_filter_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rgb_filter_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_filter_ctrl.sv
// rgb_filter_ctrl
//   Produces the per-channel attenuation code for the RGB filter datapath.
//   Board switches and the auto-mode key are synchronized and debounced. A new
//   manual code is committed only on a frame boundary, so a frame never shows
//   mixed settings. Auto mode, toggled by the key, steps through four presets
//   every AUTO_FRAMES frames.
//
// Ports
//   clk            pixel-domain clock
//   rst_n          asynchronous active-low reset
//   i_sw[5:0]      raw filter switches ([5:4] R, [3:2] G, [1:0] B), async to clk
//   i_key_n        raw auto-mode pushbutton, active-low, async to clk
//   i_frame_start  one-cycle pulse at row 0, col 0 of each frame
//   o_filter_SW    committed filter code (00 normal, 01 half, 10 quarter, 11 off)
//   o_pending      debounced manual code waiting for the next frame boundary
//   o_auto         auto-cycle mode active
module rgb_filter_ctrl #(
    parameter logic [19:0] DEBOUNCE_CYC = 20'd500000,
    parameter logic [7:0]  AUTO_FRAMES  = 8'd60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_sw,
    input  logic       i_key_n,
    input  logic       i_frame_start,
    output logic [5:0] o_filter_SW,
    output logic       o_pending,
    output logic       o_auto
);

    typedef enum logic [1:0] {
        MAN_IDLE,
        MAN_PEND,
        AUTO
    } state_t;

    localparam logic [19:0] DB_LAST = DEBOUNCE_CYC - 20'd1;
    localparam logic [7:0]  AF_LAST = AUTO_FRAMES - 8'd1;

    logic [5:0]  sw_meta, sw_sync, sw_stable;
    logic        key_meta, key_sync, key_stable;
    logic [19:0] sw_cnt, key_cnt;
    logic        key_press;
    logic        sw_differs;

    state_t      state;
    logic [1:0]  preset_idx;
    logic [7:0]  frame_cnt;
    logic        auto_first;

    function automatic logic [5:0] preset(input logic [1:0] idx);
        // NOTE: every path assigns the result, so no latch/hold logic is implied.
        case (idx)
            2'd1:    preset = 6'b010101;
            2'd2:    preset = 6'b101010;
            2'd3:    preset = 6'b001111;
            default: preset = 6'b000000;
        endcase
    endfunction

    // Two-flop synchronizers; the key idles high (released).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values, independent of statement order.
            sw_meta  <= '0;
            sw_sync  <= '0;
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            sw_meta  <= i_sw;
            sw_sync  <= sw_meta;
            key_meta <= i_key_n;
            key_sync <= key_meta;
        end
    end

    // Debouncers: the counter runs while sync differs from stable and clears on
    // any return to the stable value, discarding short bounces.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_stable  <= '0;
            sw_cnt     <= '0;
            key_stable <= 1'b1;
            key_cnt    <= '0;
        end else begin
            if (sw_sync == sw_stable) begin
                sw_cnt <= '0;
            end else if (sw_cnt == DB_LAST) begin
                sw_stable <= sw_sync;
                sw_cnt    <= '0;
            end else begin
                sw_cnt <= sw_cnt + 20'd1;
            end

            if (key_sync == key_stable) begin
                key_cnt <= '0;
            end else if (key_cnt == DB_LAST) begin
                key_stable <= key_sync;
                key_cnt    <= '0;
            end else begin
                key_cnt <= key_cnt + 20'd1;
            end
        end
    end

    // Debounced key goes 1->0 on this edge: the press event.
    assign key_press  = (key_sync != key_stable) && (key_cnt == DB_LAST) && !key_sync;
    assign sw_differs = (sw_stable != o_filter_SW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MAN_IDLE;
            o_filter_SW <= '0;
            o_pending   <= 1'b0;
            o_auto      <= 1'b0;
            preset_idx  <= '0;
            frame_cnt   <= '0;
            auto_first  <= 1'b0;
        end else if (key_press) begin
            // A key toggle wins over a coincident frame boundary: no commit here.
            if (state == AUTO) begin
                o_auto    <= 1'b0;
                state     <= sw_differs ? MAN_PEND : MAN_IDLE;
                o_pending <= sw_differs;
            end else begin
                state      <= AUTO;
                o_auto     <= 1'b1;
                o_pending  <= 1'b0;
                preset_idx <= '0;
                frame_cnt  <= '0;
                auto_first <= 1'b1;
            end
        end else begin
            case (state)
                MAN_IDLE: begin
                    // A frame start on this edge does not commit; the mismatch
                    // must first be registered as pending.
                    if (sw_differs) begin
                        state     <= MAN_PEND;
                        o_pending <= 1'b1;
                    end
                end
                MAN_PEND: begin
                    if (!sw_differs) begin
                        state     <= MAN_IDLE;
                        o_pending <= 1'b0;
                    end else if (i_frame_start) begin
                        o_filter_SW <= sw_stable;
                        o_pending   <= 1'b0;
                        state       <= MAN_IDLE;
                    end
                end
                AUTO: begin
                    if (i_frame_start) begin
                        if (auto_first) begin
                            o_filter_SW <= preset(2'd0);
                            auto_first  <= 1'b0;
                        end else if (frame_cnt == AF_LAST) begin
                            preset_idx  <= preset_idx + 2'd1;
                            frame_cnt   <= '0;
                            o_filter_SW <= preset(preset_idx + 2'd1);
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                default: state <= MAN_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_filter_ctrl.sv
// Self-checking bench for rgb_filter_ctrl with DEBOUNCE_CYC=8, AUTO_FRAMES=3.
// A behavioural model predicts the outputs every cycle; a vector table and
// hand-written sequences add fixed expectations for the key scenarios.
module tb_rgb_filter_ctrl;

    localparam int DB = 8;
    localparam int AF = 3;

    logic       clk;
    logic       rst_n;
    logic [5:0] i_sw;
    logic       i_key_n;
    logic       i_frame_start;
    logic [5:0] o_filter_SW;
    logic       o_pending;
    logic       o_auto;

    rgb_filter_ctrl #(
        .DEBOUNCE_CYC(20'd8),
        .AUTO_FRAMES (8'd3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_sw         (i_sw),
        .i_key_n      (i_key_n),
        .i_frame_start(i_frame_start),
        .o_filter_SW  (o_filter_SW),
        .o_pending    (o_pending),
        .o_auto       (o_auto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [5:0] presets [4] = '{6'h00, 6'h15, 6'h2A, 6'h0F};
    logic [5:0] m_sw_hist[$];   // raw samples, newest first
    logic       m_key_hist[$];
    logic [5:0] m_sw_stable;
    logic       m_key_stable;
    int         m_sw_run, m_key_run;
    logic [5:0] m_out;
    logic       m_pend, m_auto;
    int         m_frames;       // frame starts seen since entering auto

    task automatic model_reset();
        m_sw_hist    = '{6'd0, 6'd0};
        m_key_hist   = '{1'b1, 1'b1};
        m_sw_stable  = '0;
        m_key_stable = 1'b1;
        m_sw_run     = 0;
        m_key_run    = 0;
        m_out        = '0;
        m_pend       = 1'b0;
        m_auto       = 1'b0;
        m_frames     = 0;
    endtask

    // One clock edge: inputs are the values present at that edge.
    task automatic model_step(input logic [5:0] sw, input logic key_n, input logic fs);
        logic [5:0] sync_sw;
        logic       sync_key;
        logic [5:0] old_stable;
        logic       press;
        logic       mismatch;
        logic       commit;
        sync_sw    = m_sw_hist[1];   // raw value two edges back
        sync_key   = m_key_hist[1];
        old_stable = m_sw_stable;
        press      = 1'b0;

        // A value is accepted after DB consecutive edges differing from stable.
        if (sync_sw != m_sw_stable) begin
            m_sw_run++;
            if (m_sw_run == DB) begin
                m_sw_stable = sync_sw;
                m_sw_run    = 0;
            end
        end else m_sw_run = 0;

        if (sync_key != m_key_stable) begin
            m_key_run++;
            if (m_key_run == DB) begin
                m_key_stable = sync_key;
                m_key_run    = 0;
                press        = (sync_key == 1'b0);
            end
        end else m_key_run = 0;

        m_sw_hist.push_front(sw);
        void'(m_sw_hist.pop_back());
        m_key_hist.push_front(key_n);
        void'(m_key_hist.pop_back());

        mismatch = (old_stable != m_out);
        if (press) begin
            if (m_auto) begin
                m_auto = 1'b0;
                m_pend = mismatch;
            end else begin
                m_auto   = 1'b1;
                m_pend   = 1'b0;
                m_frames = 0;
            end
        end else if (m_auto) begin
            if (fs) begin
                m_frames++;
                if ((m_frames - 1) % AF == 0)
                    m_out = presets[((m_frames - 1) / AF) % 4];
            end
        end else begin
            commit = m_pend && fs && mismatch;
            if (commit) m_out = old_stable;
            m_pend = mismatch && !commit;
        end
    endtask

    // Entered at a falling edge: drive, let one rising edge pass, compare.
    task automatic tick(input logic [5:0] sw, input logic key_n, input logic fs);
        i_sw          = sw;
        i_key_n       = key_n;
        i_frame_start = fs;
        @(posedge clk);
        model_step(sw, key_n, fs);
        @(negedge clk);
        check("cyc_filter",  {26'd0, o_filter_SW}, {26'd0, m_out});
        check("cyc_pending", {31'd0, o_pending},   {31'd0, m_pend});
        check("cyc_auto",    {31'd0, o_auto},      {31'd0, m_auto});
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        i_sw          = '0;
        i_key_n       = 1'b1;
        i_frame_start = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_filter",  {26'd0, o_filter_SW}, 32'd0);
        check("rst_pending", {31'd0, o_pending},   32'd0);
        check("rst_auto",    {31'd0, o_auto},      32'd0);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic [5:0] sw;
        logic       key_n;
        logic       fs;      // frame start pulsed on the last cycle of the row
        int         cycles;
        logic [5:0] exp_f;
        logic       exp_p;
        logic       exp_a;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string name, input logic [5:0] sw, input logic key_n,
                           input logic fs, input int cycles, input logic [5:0] exp_f,
                           input logic exp_p, input logic exp_a);
        vec_t v;
        v.name = name; v.sw = sw; v.key_n = key_n; v.fs = fs; v.cycles = cycles;
        v.exp_f = exp_f; v.exp_p = exp_p; v.exp_a = exp_a;
        vecs.push_back(v);
    endtask

    logic [5:0] r_sw;
    logic       r_key;
    int         sw_hold, key_hold;

    initial begin
        rst_n = 1'b0;
        i_sw = '0; i_key_n = 1'b1; i_frame_start = 1'b0;

        add_vec("idle",          6'h00, 1, 0,  4, 6'h00, 0, 0);
        add_vec("db_wait",       6'h06, 1, 0, 10, 6'h00, 0, 0);
        add_vec("pend_set",      6'h06, 1, 0,  1, 6'h00, 1, 0);
        add_vec("pend_hold",     6'h06, 1, 0,  5, 6'h00, 1, 0);
        add_vec("commit",        6'h06, 1, 1,  1, 6'h06, 0, 0);
        add_vec("no_change",     6'h06, 1, 1,  3, 6'h06, 0, 0);
        add_vec("coinc_fs",      6'h30, 1, 1, 10, 6'h06, 0, 0);
        add_vec("coinc_pend",    6'h30, 1, 0,  1, 6'h06, 1, 0);
        add_vec("coinc_commit",  6'h30, 1, 1,  2, 6'h30, 0, 0);
        add_vec("key_press",     6'h30, 0, 0, 12, 6'h30, 0, 1);
        add_vec("auto_f1",       6'h30, 1, 1,  2, 6'h00, 0, 1);
        add_vec("auto_f2",       6'h30, 1, 1,  2, 6'h00, 0, 1);
        add_vec("auto_f3",       6'h30, 1, 1,  2, 6'h00, 0, 1);
        add_vec("auto_f4",       6'h30, 1, 1,  2, 6'h15, 0, 1);
        add_vec("auto_f5",       6'h30, 1, 1,  2, 6'h15, 0, 1);
        add_vec("auto_f6",       6'h30, 1, 1,  2, 6'h15, 0, 1);
        add_vec("auto_f7",       6'h30, 1, 1,  2, 6'h2A, 0, 1);
        add_vec("auto_f8",       6'h30, 1, 1,  2, 6'h2A, 0, 1);
        add_vec("auto_f9",       6'h30, 1, 1,  2, 6'h2A, 0, 1);
        add_vec("auto_f10",      6'h30, 1, 1,  2, 6'h0F, 0, 1);
        add_vec("auto_f11",      6'h30, 1, 1,  2, 6'h0F, 0, 1);
        add_vec("auto_f12",      6'h30, 1, 1,  2, 6'h0F, 0, 1);
        add_vec("auto_f13",      6'h30, 1, 1,  2, 6'h00, 0, 1);
        add_vec("exit_sw",       6'h3F, 1, 0, 12, 6'h00, 0, 1);
        add_vec("exit_key",      6'h3F, 0, 0, 12, 6'h00, 1, 0);
        add_vec("exit_commit",   6'h3F, 1, 1, 12, 6'h3F, 0, 0);
        add_vec("key_fs_coinc",  6'h3F, 0, 1, 10, 6'h3F, 0, 1);
        add_vec("auto_reentry",  6'h3F, 1, 1,  2, 6'h00, 0, 1);

        // Reset while a code is pending, then re-debounce and commit.
        do_reset();
        repeat (12) tick(6'h30, 1'b1, 1'b0);
        check("mid_pend_before_rst", {31'd0, o_pending}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_filter",  {26'd0, o_filter_SW}, 32'd0);
        check("async_rst_pending", {31'd0, o_pending},   32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick(6'h30, 1'b1, 1'b0);
        check("redebounce_wait", {31'd0, o_pending}, 32'd0);
        tick(6'h30, 1'b1, 1'b0);
        check("redebounce_pend", {31'd0, o_pending}, 32'd1);
        tick(6'h30, 1'b1, 1'b1);
        check("redebounce_commit", {26'd0, o_filter_SW}, 32'h30);

        // Bounce rejection: toggling every 3 cycles never reaches the threshold.
        do_reset();
        for (int c = 0; c < 40; c++) begin
            tick(((c / 3) % 2) != 0 ? 6'h03 : 6'h00, 1'b1, 1'b0);
            check("bounce_pending", {31'd0, o_pending}, 32'd0);
        end
        repeat (12) tick(6'h00, 1'b1, 1'b1);
        check("bounce_filter",  {26'd0, o_filter_SW}, 32'd0);
        check("bounce_pending_end", {31'd0, o_pending}, 32'd0);

        // Table-driven scenarios.
        do_reset();
        foreach (vecs[k]) begin
            for (int c = 0; c < vecs[k].cycles; c++)
                tick(vecs[k].sw, vecs[k].key_n, vecs[k].fs && (c == vecs[k].cycles - 1));
            check({vecs[k].name, "_filter"},  {26'd0, o_filter_SW}, {26'd0, vecs[k].exp_f});
            check({vecs[k].name, "_pending"}, {31'd0, o_pending},   {31'd0, vecs[k].exp_p});
            check({vecs[k].name, "_auto"},    {31'd0, o_auto},      {31'd0, vecs[k].exp_a});
        end

        // Randomized traffic against the model.
        do_reset();
        r_sw = '0; r_key = 1'b1; sw_hold = 0; key_hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (sw_hold == 0) begin
                r_sw    = 6'($urandom);
                sw_hold = $urandom_range(1, 24);
            end
            if (key_hold == 0) begin
                r_key    = ~r_key;
                key_hold = r_key ? $urandom_range(3, 60) : $urandom_range(2, 20);
            end
            sw_hold--;
            key_hold--;
            tick(r_sw, r_key, $urandom_range(0, 11) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
